// File: rtl/ls_pkg.sv
// Shared definitions for the load/store sequencer:
// opcodes, size codes, state encoding and decode helpers.
package ls_pkg;

    localparam logic [5:0] OP_LB = 6'h20;
    localparam logic [5:0] OP_LH = 6'h21;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2b;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_CAP  = 3'd2,
        S_WB      = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_FAULT   = 3'd6
    } state_e;

    function automatic logic ls_supported(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW ||
               op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic ls_is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW;
    endfunction

    function automatic logic ls_misaligned(input logic [5:0] op,
                                           input logic [1:0] addr_lo);
        logic word;
        logic half;
        word = op == OP_LW || op == OP_SW;
        half = op == OP_LH || op == OP_SH;
        return (word && addr_lo != 2'b00) || (half && addr_lo[0]);
    endfunction

    function automatic size_e ls_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_SB) return SZ_BYTE;
        if (op == OP_LH || op == OP_SH) return SZ_HALF;
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/ls_wait_counter.sv
// 4-bit memory wait-state down-counter; expired flags a zero count.
// Load wins over enable; the count saturates at zero.
module ls_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = cnt_q == 4'd0;

endmodule

// File: rtl/ls_sequencer.sv
// Multicycle load/store sequencer for the MIPS datapath.
// Byte/half stores run as read-modify-write through the MDR.
module ls_sequencer
    import ls_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int OPC_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       addr_lo,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             mem_addr_sel,
    output logic             mem_wr,
    output logic             mdr_wr,
    output logic             reg_wr,
    output logic [1:0]       size,
    output logic [1:0]       offset
);

    state_e     state_q, state_d;
    logic       load_q, load_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;
    logic       sel_q, sel_d;
    logic       mem_wr_q, mem_wr_d;
    logic       mdr_wr_q, mdr_wr_d;
    logic       reg_wr_q, reg_wr_d;
    logic [1:0] size_q, size_d;
    logic [1:0] offset_q, offset_d;
    logic       cnt_load;
    logic       cnt_en;
    logic       expired;
    logic [5:0] op;

    assign op = 6'(opcode);

    ls_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (4'(MEM_LAT - 1)),
        .en       (cnt_en),
        .expired  (expired)
    );

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        cnt_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d = ls_is_load(op);
                    if (!ls_supported(op) || ls_misaligned(op, addr_lo))
                        state_d = S_FAULT;
                    else if (op == OP_SW)
                        state_d = S_WR_WAIT;
                    else
                        state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (expired) state_d = S_RD_CAP;
                else         cnt_en  = 1'b1;
            end
            S_RD_CAP:  state_d = load_q ? S_WB : S_WR_WAIT;
            S_WB:      state_d = S_DONE;
            S_WR_WAIT: begin
                if (expired) state_d = S_DONE;
                else         cnt_en  = 1'b1;
            end
            S_DONE:    state_d = S_IDLE;
            S_FAULT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign cnt_load = state_d != state_q &&
                      (state_d == S_RD_WAIT || state_d == S_WR_WAIT);

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        busy_d   = state_d != S_IDLE;
        done_d   = state_d == S_DONE || state_d == S_FAULT;
        fault_d  = state_d == S_FAULT;
        sel_d    = state_d == S_RD_WAIT || state_d == S_RD_CAP ||
                   state_d == S_WR_WAIT;
        mem_wr_d = state_d == S_WR_WAIT;
        mdr_wr_d = state_d == S_RD_CAP;
        reg_wr_d = state_d == S_WB;
        size_d   = size_q;
        offset_d = offset_q;
        if (state_d == S_IDLE) begin
            size_d   = 2'b00;
            offset_d = 2'b00;
        end else if (state_q == S_IDLE) begin
            size_d   = ls_size(op);
            offset_d = addr_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            sel_q    <= 1'b0;
            mem_wr_q <= 1'b0;
            mdr_wr_q <= 1'b0;
            reg_wr_q <= 1'b0;
            size_q   <= 2'b00;
            offset_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            sel_q    <= sel_d;
            mem_wr_q <= mem_wr_d;
            mdr_wr_q <= mdr_wr_d;
            reg_wr_q <= reg_wr_d;
            size_q   <= size_d;
            offset_q <= offset_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign mem_addr_sel = sel_q;
    assign mem_wr       = mem_wr_q;
    assign mdr_wr       = mdr_wr_q;
    assign reg_wr       = reg_wr_q;
    assign size         = size_q;
    assign offset       = offset_q;

endmodule
